// File: rtl/shared_mem_arbiter.sv
// Shared word memory behind N round-robin arbitrated request ports; one grant per cycle,
// completions READ_LAT cycles after the grant cycle, byte-masked reads and writes.
module shared_mem_arbiter #(
   parameter int N_PORTS  = 2,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 256,
   parameter int READ_LAT = 1,
   localparam int ADDR_W  = $clog2(DEPTH),
   localparam int NB      = DATA_W / 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_PORTS-1:0]          request,
   input  logic [N_PORTS-1:0]          we_re,
   input  logic [N_PORTS*ADDR_W-1:0]   address,
   input  logic [N_PORTS*DATA_W-1:0]   data_in,
   input  logic [N_PORTS*NB-1:0]       mask,
   output logic [N_PORTS-1:0]          grant,
   output logic [N_PORTS-1:0]          valid,
   output logic [N_PORTS*DATA_W-1:0]   data_out
);

   localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef struct packed {
      logic              vld;
      logic [PTR_W-1:0]  port;
      logic              we;
      logic [DATA_W-1:0] dat;
   } stage_t;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [N_PORTS-1:0] pending;
   logic [N_PORTS-1:0] eligible;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   gnt_idx;
   logic               gnt_any;

   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic [NB-1:0]     sel_mask;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rd_masked;

   stage_t cur;
   stage_t tail;

   // A port in its valid cycle is still pending, so the valid term is belt-and-braces.
   always_comb begin
      eligible = request & ~pending & ~valid & {N_PORTS{~rst}};
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      grant    = '0;
      for (int off = 0; off < N_PORTS; off++) begin
         int idx;
         idx = (int'(ptr) + off) % N_PORTS;
         if (!gnt_any && eligible[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(idx);
         end
      end
      if (gnt_any) grant[gnt_idx] = 1'b1;
   end

   always_comb begin
      sel_we    = we_re[gnt_idx];
      sel_addr  = address[int'(gnt_idx)*ADDR_W +: ADDR_W];
      sel_data  = data_in[int'(gnt_idx)*DATA_W +: DATA_W];
      sel_mask  = mask[int'(gnt_idx)*NB +: NB];
      rd_word   = mem[sel_addr];
      rd_masked = '0;
      for (int b = 0; b < NB; b++) begin
         if (sel_mask[b]) rd_masked[b*8 +: 8] = rd_word[b*8 +: 8];
      end
      cur.vld  = gnt_any;
      cur.port = gnt_idx;
      cur.we   = sel_we;
      cur.dat  = rd_masked;
   end

   // Memory contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (gnt_any && sel_we) begin
         for (int b = 0; b < NB; b++) begin
            if (sel_mask[b]) mem[sel_addr][b*8 +: 8] <= sel_data[b*8 +: 8];
         end
      end
   end

   generate
      if (READ_LAT == 1) begin : g_direct
         assign tail = cur;
      end else begin : g_pipe
         stage_t pipe [READ_LAT-1];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < READ_LAT-1; s++) pipe[s] <= '0;
            end else begin
               pipe[0] <= cur;
               for (int s = 1; s < READ_LAT-1; s++) pipe[s] <= pipe[s-1];
            end
         end
         assign tail = pipe[READ_LAT-2];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid    <= '0;
         data_out <= '0;
         pending  <= '0;
         ptr      <= '0;
      end else begin
         valid <= '0;
         if (tail.vld) begin
            valid[tail.port] <= 1'b1;
            if (!tail.we) data_out[int'(tail.port)*DATA_W +: DATA_W] <= tail.dat;
         end
         pending <= (pending & ~valid) | grant;
         if (gnt_any) begin
            ptr <= (gnt_idx == PTR_W'(N_PORTS-1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench: two-port arbiter at READ_LAT=2 plus a READ_LAT=3 instance for reset-in-flight.
module tb_shared_mem_arbiter;

   logic        clk;
   logic        rst;

   logic [1:0]  request, we_re, grant, valid;
   logic [15:0] address;
   logic [63:0] data_in, data_out;
   logic [7:0]  mask;

   logic [1:0]  r3, w3, g3, v3;
   logic [15:0] a3;
   logic [63:0] d3, do3;
   logic [7:0]  m3;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   localparam logic [1:0] G4 [0:6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
   localparam logic [1:0] V4 [0:6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};

   shared_mem_arbiter #(.N_PORTS(2), .DATA_W(32), .DEPTH(256), .READ_LAT(2)) dut (
      .clk(clk), .rst(rst), .request(request), .we_re(we_re), .address(address),
      .data_in(data_in), .mask(mask), .grant(grant), .valid(valid), .data_out(data_out)
   );

   shared_mem_arbiter #(.N_PORTS(2), .DATA_W(32), .DEPTH(256), .READ_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .request(r3), .we_re(w3), .address(a3),
      .data_in(d3), .mask(m3), .grant(g3), .valid(v3), .data_out(do3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge; returns at the negedge where this port's valid is high.
   task automatic txn(input int p, input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] m, input string tag);
      request[p]          = 1'b1;
      we_re[p]            = w;
      address[p*8 +: 8]   = a;
      data_in[p*32 +: 32] = d;
      mask[p*4 +: 4]      = m;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (grant[p]) break;
         @(negedge clk);
      end
      chk({tag, "_grant"}, 64'(grant), 64'(1) << p);
      @(negedge clk);
      chk({tag, "_no_early_valid"}, 64'(valid), 64'(0));
      @(negedge clk);
      chk({tag, "_valid"}, 64'(valid), 64'(1) << p);
      request[p] = 1'b0;
   endtask

   task automatic do_reset();
      request = '0;
      r3      = '0;
      rst     = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      clk = 1'b0; rst = 1'b1;
      request = '0; we_re = '0; address = '0; data_in = '0; mask = '0;
      r3 = '0; w3 = '0; a3 = '0; d3 = '0; m3 = '0;

      @(negedge clk);
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_valid", 64'(valid), 64'(0));
      chk("rst_data_out", data_out, 64'(0));
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_grant", 64'(grant), 64'(0));
         chk("idle_valid", 64'(valid), 64'(0));
      end

      // Port 1: full write, masked read, partial write, full read.
      txn(1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, "wr_full");
      chk("wr_ack_keeps_data", data_out, 64'(0));
      txn(1, 1'b0, 8'h10, 32'h0, 4'h3, "rd_mask");
      chk("rd_mask_data", 64'(data_out[63:32]), 64'h0000BEEF);
      txn(1, 1'b1, 8'h10, 32'h00AA0000, 4'b0100, "wr_part");
      chk("wr_part_keeps_data", 64'(data_out[63:32]), 64'h0000BEEF);
      txn(1, 1'b0, 8'h10, 32'h0, 4'hF, "rd_full");
      chk("rd_full_data", 64'(data_out[63:32]), 64'hDEAABEEF);

      // Asynchronous reset while valid is high.
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(valid), 64'(0));
      chk("async_rst_data_out", data_out, 64'(0));
      @(negedge clk);
      rst = 1'b0;

      // Both ports read continuously: alternating grants from port 0.
      we_re = 2'b00; mask = 8'hFF; address = {8'h30, 8'h10};
      request = 2'b11;
      for (int c = 0; c < 7; c++) begin
         #1;
         chk($sformatf("rr_grant_c%0d", c), 64'(grant), 64'(G4[c]));
         chk($sformatf("rr_valid_c%0d", c), 64'(valid), 64'(V4[c]));
         if (c == 2) chk("rr_p0_data", 64'(data_out[31:0]), 64'hDEAABEEF);
         @(negedge clk);
      end
      do_reset();

      // Back-to-back write (port 0) then read (port 1) of the same word.
      we_re = 2'b01; address = {8'h20, 8'h20}; data_in = {32'h0, 32'h12345678}; mask = 8'hFF;
      request = 2'b11;
      #1; chk("raw_grant_c0", 64'(grant), 64'h1);
      @(negedge clk);
      #1; chk("raw_grant_c1", 64'(grant), 64'h2);
      @(negedge clk);
      chk("raw_valid_c2", 64'(valid), 64'h1);
      request[0] = 1'b0;
      @(negedge clk);
      chk("raw_valid_c3", 64'(valid), 64'h2);
      chk("raw_data", 64'(data_out[63:32]), 64'h12345678);
      request[1] = 1'b0;
      do_reset();

      // READ_LAT=3 instance: write, then reset with a read in flight.
      r3 = 2'b01; w3 = 2'b01; a3 = {8'h05, 8'h05}; d3 = {32'h0, 32'hCAFEF00D}; m3 = 8'hFF;
      #1; chk("l3_wr_grant", 64'(g3), 64'h1);
      @(negedge clk);
      chk("l3_wr_wait1", 64'(v3), 64'(0));
      @(negedge clk);
      chk("l3_wr_wait2", 64'(v3), 64'(0));
      @(negedge clk);
      chk("l3_wr_valid", 64'(v3), 64'h1);
      w3 = 2'b00;
      @(negedge clk);
      #1; chk("l3_rd_grant", 64'(g3), 64'h1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("l3_rst_valid", 64'(v3), 64'(0));
      chk("l3_rst_data_out", do3, 64'(0));
      @(negedge clk);
      rst = 1'b0;
      r3 = 2'b11;
      #1; chk("l3_regrant_p0", 64'(g3), 64'h1);
      @(negedge clk);
      chk("l3_flushed_c1", 64'(v3), 64'(0));
      chk("l3_data_zero", do3, 64'(0));
      @(negedge clk);
      chk("l3_flushed_c2", 64'(v3), 64'(0));
      @(negedge clk);
      chk("l3_p0_valid", 64'(v3), 64'h1);
      chk("l3_p0_data", 64'(do3[31:0]), 64'hCAFEF00D);
      r3[0] = 1'b0;
      @(negedge clk);
      chk("l3_p1_valid", 64'(v3), 64'h2);
      chk("l3_p1_data", 64'(do3[63:32]), 64'hCAFEF00D);
      r3 = 2'b00;
      @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
